count_checker: RTL and testbench

- Passive monitor on the receiving end of an N-bit up-counter interface (Enable, Clear, count value X).
- Rebuilds the expected count from the counter's own Enable/Clear stream and checks every sampled X against it.
- Reports mismatches and terminal-count completion, so counter benches self-check instead of relying on printed output.
- Sits beside the counter DUT and observes only; it never drives the counter.

---
 rtl/count_checker_if.sv | 30 +++
 rtl/count_checker.sv | 106 ++++++++++
 tb/tb_count_checker.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/count_checker_if.sv
// Bundles the observed counter signals (Enable, Clear, X) and the checker's status outputs.
// master = counter/bench side, slave = checker side.
`default_nettype none

interface count_checker_if #(
    parameter int N     = 4,
    parameter int ERR_W = 8
);
    logic             Enable;
    logic             Clear;
    logic [N-1:0]     X;
    logic             Done;
    logic             Error;
    logic             ErrSeen;
    logic [ERR_W-1:0] ErrCount;
    logic [N-1:0]     FirstBad;
    logic             Tracking;

    modport master (
        output Enable, Clear, X,
        input  Done, Error, ErrSeen, ErrCount, FirstBad, Tracking
    );

    modport slave (
        input  Enable, Clear, X,
        output Done, Error, ErrSeen, ErrCount, FirstBad, Tracking
    );
endinterface

`default_nettype wire

// File: rtl/count_checker.sv
// Passive checker for an N-bit up-counter: rebuilds the expected count from the
// counter's own Enable/Clear history and flags every sample that disagrees.
`default_nettype none

module count_checker #(
    parameter int N           = 4,
    parameter bit STOP_AT_MAX = 1'b1,
    parameter int ERR_W       = 8
) (
    input  wire logic       clk_i,
    input  wire logic       resetn_i,
    count_checker_if.slave  bus
);
    typedef enum logic [1:0] {
        S_SYNC  = 2'd0,
        S_TRACK = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [N-1:0]     ONE      = N'(1);
    localparam logic [N-1:0]     ALL_ONES = {N{1'b1}};
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    state_t           state_q;
    logic [N-1:0]     prev_x_q;
    logic             prev_en_q;
    logic             prev_clr_q;
    logic             done_q;
    logic             error_q;
    logic             err_seen_q;
    logic [ERR_W-1:0] err_count_q;
    logic [N-1:0]     first_bad_q;
    logic             tracking_q;

    logic [N-1:0]     expected;
    logic             mismatch;

    // Clear beats Enable, matching the counter being checked.
    assign expected = prev_clr_q ? '0 : (prev_en_q ? prev_x_q + ONE : prev_x_q);
    assign mismatch = (bus.X != expected);

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q     <= S_SYNC;
            prev_x_q    <= '0;
            prev_en_q   <= 1'b0;
            prev_clr_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_seen_q  <= 1'b0;
            err_count_q <= '0;
            first_bad_q <= '0;
            tracking_q  <= 1'b0;
        end else begin
            case (state_q)
                S_SYNC: begin
                    prev_x_q   <= bus.X;
                    prev_en_q  <= bus.Enable;
                    prev_clr_q <= bus.Clear;
                    error_q    <= 1'b0;
                    tracking_q <= 1'b1;
                    state_q    <= S_TRACK;
                end
                S_TRACK: begin
                    // Capturing the actual X resyncs the model after a bad sample.
                    prev_x_q   <= bus.X;
                    prev_en_q  <= bus.Enable;
                    prev_clr_q <= bus.Clear;
                    error_q    <= mismatch;
                    if (mismatch) begin
                        if (err_count_q != ERR_MAX) begin
                            err_count_q <= err_count_q + ERR_W'(1);
                        end
                        if (!err_seen_q) begin
                            first_bad_q <= bus.X;
                            err_seen_q  <= 1'b1;
                        end
                    end else if (STOP_AT_MAX && (bus.X == ALL_ONES)) begin
                        done_q     <= 1'b1;
                        tracking_q <= 1'b0;
                        state_q    <= S_HALT;
                    end
                end
                S_HALT: begin
                    error_q    <= 1'b0;
                    tracking_q <= 1'b0;
                end
                default: begin
                    error_q    <= 1'b0;
                    tracking_q <= 1'b0;
                    state_q    <= S_SYNC;
                end
            endcase
        end
    end

    assign bus.Done     = done_q;
    assign bus.Error    = error_q;
    assign bus.ErrSeen  = err_seen_q;
    assign bus.ErrCount = err_count_q;
    assign bus.FirstBad = first_bad_q;
    assign bus.Tracking = tracking_q;

endmodule

`default_nettype wire

// File: tb/tb_count_checker.sv
// Directed bench for count_checker: three instances cover STOP_AT_MAX=1/0 and a narrow error counter.
`default_nettype none

module tb_count_checker;
    logic       clk;
    logic       resetn;
    logic       en;
    logic       clr;
    logic [3:0] x;
    int         checks;
    int         errors;

    count_checker_if #(.N(4), .ERR_W(8)) if_a ();
    count_checker_if #(.N(4), .ERR_W(8)) if_b ();
    count_checker_if #(.N(4), .ERR_W(2)) if_c ();

    assign if_a.Enable = en;
    assign if_a.Clear  = clr;
    assign if_a.X      = x;
    assign if_b.Enable = en;
    assign if_b.Clear  = clr;
    assign if_b.X      = x;
    assign if_c.Enable = en;
    assign if_c.Clear  = clr;
    assign if_c.X      = x;

    count_checker #(.N(4), .STOP_AT_MAX(1'b1), .ERR_W(8)) u_a (
        .clk_i(clk), .resetn_i(resetn), .bus(if_a));
    count_checker #(.N(4), .STOP_AT_MAX(1'b0), .ERR_W(8)) u_b (
        .clk_i(clk), .resetn_i(resetn), .bus(if_b));
    count_checker #(.N(4), .STOP_AT_MAX(1'b1), .ERR_W(2)) u_c (
        .clk_i(clk), .resetn_i(resetn), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edge plus an ideal counter update driven from the Enable/Clear seen at that edge.
    task automatic step();
        tick();
        if (clr) x = 4'd0;
        else if (en) x = x + 4'd1;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        en = 1'b0;
        clr = 1'b0;
        x = 4'd0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        en = 1'b1;
        clr = 1'b0;
        x = 4'd9;
        tick();
        checks++;
        if ({if_a.Done, if_a.Error, if_a.ErrSeen, if_a.Tracking} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {if_a.Done, if_a.Error, if_a.ErrSeen, if_a.Tracking});
        end
        checks++;
        if (if_a.ErrCount !== 8'd0 || if_a.FirstBad !== 4'd0 || if_c.ErrCount !== 2'd0) begin
            errors++;
            $display("FAIL reset_values: ErrCount=%0d FirstBad=%0d C.ErrCount=%0d expected 0",
                     if_a.ErrCount, if_a.FirstBad, if_c.ErrCount);
        end
        resetn = 1'b1;
    endtask

    task automatic test_count_to_max();
        apply_reset();
        en = 1'b1;
        step();
        checks++;
        if (if_a.Tracking !== 1'b1 || if_a.Error !== 1'b0) begin
            errors++;
            $display("FAIL sync_to_track: Tracking=%b Error=%b expected 1 0", if_a.Tracking, if_a.Error);
        end
        for (int i = 1; i <= 15; i++) begin
            step();
            checks++;
            if (if_a.Error !== 1'b0) begin
                errors++;
                $display("FAIL count_error[%0d]: got %b expected 0", i, if_a.Error);
            end
            checks++;
            if (if_a.Done !== (i == 15) || if_a.Tracking !== (i != 15)) begin
                errors++;
                $display("FAIL count_done[%0d]: Done=%b Tracking=%b expected %b %b",
                         i, if_a.Done, if_a.Tracking, (i == 15), (i != 15));
            end
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (if_a.Done !== 1'b1 || if_a.Error !== 1'b0 || if_a.Tracking !== 1'b0
                || if_a.ErrCount !== 8'd0) begin
                errors++;
                $display("FAIL halt_frozen[%0d]: Done=%b Error=%b Tracking=%b ErrCount=%0d expected 1 0 0 0",
                         i, if_a.Done, if_a.Error, if_a.Tracking, if_a.ErrCount);
            end
        end
    endtask

    task automatic test_enable_clear();
        logic [9:0] en_tab;
        logic [9:0] clr_tab;
        en_tab  = 10'b1111110011;
        clr_tab = 10'b0010000000;
        apply_reset();
        en = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            en  = en_tab[i];
            clr = clr_tab[i];
            step();
            clr = 1'b0;
            checks++;
            if (if_a.Error !== 1'b0) begin
                errors++;
                $display("FAIL en_clr_error[%0d]: got %b expected 0", i, if_a.Error);
            end
        end
        checks++;
        if (if_a.ErrSeen !== 1'b0 || if_a.ErrCount !== 8'd0 || if_a.Tracking !== 1'b1) begin
            errors++;
            $display("FAIL en_clr_final: ErrSeen=%b ErrCount=%0d Tracking=%b expected 0 0 1",
                     if_a.ErrSeen, if_a.ErrCount, if_a.Tracking);
        end
    endtask

    task automatic test_skip();
        apply_reset();
        en = 1'b1;
        step();
        repeat (4) step();
        x = 4'd6;
        step();
        checks++;
        if (if_a.Error !== 1'b1 || if_a.ErrSeen !== 1'b1) begin
            errors++;
            $display("FAIL skip_flag: Error=%b ErrSeen=%b expected 1 1", if_a.Error, if_a.ErrSeen);
        end
        checks++;
        if (if_a.FirstBad !== 4'd6 || if_a.ErrCount !== 8'd1) begin
            errors++;
            $display("FAIL skip_values: FirstBad=%0d ErrCount=%0d expected 6 1", if_a.FirstBad, if_a.ErrCount);
        end
        step();
        checks++;
        if (if_a.Error !== 1'b0 || if_a.ErrCount !== 8'd1 || if_a.FirstBad !== 4'd6) begin
            errors++;
            $display("FAIL skip_resync: Error=%b ErrCount=%0d FirstBad=%0d expected 0 1 6",
                     if_a.Error, if_a.ErrCount, if_a.FirstBad);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        en = 1'b1;
        step();
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if (if_b.Error !== 1'b0 || if_b.Done !== 1'b0 || if_b.Tracking !== 1'b1) begin
                errors++;
                $display("FAIL wrap[%0d]: Error=%b Done=%b Tracking=%b expected 0 0 1",
                         i, if_b.Error, if_b.Done, if_b.Tracking);
            end
        end
        checks++;
        if (if_b.ErrCount !== 8'd0) begin
            errors++;
            $display("FAIL wrap_errcount: got %0d expected 0", if_b.ErrCount);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_cnt;
        apply_reset();
        en = 1'b1;
        x = 4'd3;
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
            checks++;
            if (if_c.Error !== 1'b1 || if_c.ErrCount !== exp_cnt || if_c.FirstBad !== 4'd3) begin
                errors++;
                $display("FAIL saturate[%0d]: Error=%b ErrCount=%0d FirstBad=%0d expected 1 %0d 3",
                         i, if_c.Error, if_c.ErrCount, if_c.FirstBad, exp_cnt);
            end
        end
        en = 1'b0;
        tick();
        tick();
        checks++;
        if (if_c.Error !== 1'b0 || if_c.ErrCount !== 2'd3) begin
            errors++;
            $display("FAIL saturate_hold: Error=%b ErrCount=%0d expected 0 3", if_c.Error, if_c.ErrCount);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        en = 1'b1;
        step();
        step();
        step();
        x = 4'd9;
        step();
        x = 4'd12;
        step();
        checks++;
        if (if_a.ErrCount !== 8'd2 || if_a.FirstBad !== 4'd9) begin
            errors++;
            $display("FAIL mid_pre: ErrCount=%0d FirstBad=%0d expected 2 9", if_a.ErrCount, if_a.FirstBad);
        end
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        checks++;
        if ({if_a.Done, if_a.Error, if_a.ErrSeen, if_a.Tracking} !== 4'b0000
            || if_a.ErrCount !== 8'd0 || if_a.FirstBad !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset: flags=%b ErrCount=%0d FirstBad=%0d expected 0000 0 0",
                     {if_a.Done, if_a.Error, if_a.ErrSeen, if_a.Tracking}, if_a.ErrCount, if_a.FirstBad);
        end
        step();
        checks++;
        if (if_a.Tracking !== 1'b1 || if_a.Error !== 1'b0) begin
            errors++;
            $display("FAIL mid_sync: Tracking=%b Error=%b expected 1 0", if_a.Tracking, if_a.Error);
        end
        step();
        checks++;
        if (if_a.Done !== 1'b1 || if_a.Error !== 1'b0 || if_a.ErrCount !== 8'd0) begin
            errors++;
            $display("FAIL mid_resume: Done=%b Error=%b ErrCount=%0d expected 1 0 0",
                     if_a.Done, if_a.Error, if_a.ErrCount);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        en = 1'b0;
        clr = 1'b0;
        x = 4'd0;
        test_reset();
        test_count_to_max();
        test_enable_clear();
        test_skip();
        test_wrap();
        test_saturate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
